// File: rtl/shift_unit.sv
// Multicycle shift register: loads a word, then shifts it one bit per cycle as set by sr_ctrl/sr_n.
// Define SHIFT_UNIT_ROTATE_EN to enable ROR/ROL (codes 101/110); otherwise those codes act as NOP.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         sr_ctrl,
  input  logic [SHAMT_W-1:0] sr_n,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  state_t               state, state_next;
  logic [WIDTH-1:0]     data_q, data_next;
  logic [SHAMT_W-1:0]   count, count_next;
  logic [2:0]           op, op_next;
  logic                 is_shift;

  always_comb begin
    is_shift = 1'b0;
    case (sr_ctrl)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR, OP_ROL:         is_shift = 1'b1;
`endif
      default:                is_shift = 1'b0;
    endcase
  end

  // op is latched at accept so mid-shift changes on sr_ctrl/sr_n cannot disturb the result
  always_comb begin
    state_next = state;
    data_next  = data_q;
    count_next = count;
    op_next    = op;
    case (state)
      IDLE: begin
        if (sr_ctrl == OP_LOAD) begin
          data_next  = data_in;
          state_next = DONE;
        end else if (is_shift) begin
          op_next = sr_ctrl;
          if (sr_n != '0) begin
            count_next = sr_n;
            state_next = SHIFT;
          end else begin
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        case (op)
          OP_SLL:  data_next = {data_q[WIDTH-2:0], 1'b0};
          OP_SRL:  data_next = {1'b0, data_q[WIDTH-1:1]};
          OP_SRA:  data_next = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`ifdef SHIFT_UNIT_ROTATE_EN
          OP_ROR:  data_next = {data_q[0], data_q[WIDTH-1:1]};
          OP_ROL:  data_next = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
          default: data_next = data_q;
        endcase
        count_next = count - SHAMT_W'(1);
        if (count == SHAMT_W'(1)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      count  <= '0;
      op     <= '0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      count  <= count_next;
      op     <= op_next;
    end
  end

  assign data_out = data_q;
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed self-checking bench for shift_unit; rotate expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  sr_ctrl;
  logic [4:0]  sr_n;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SLL  = 3'b010;
  localparam logic [2:0] SRL  = 3'b011;
  localparam logic [2:0] SRA  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] ROL  = 3'b110;

  shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .sr_ctrl  (sr_ctrl),
    .sr_n     (sr_n),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] ctrl, input logic [4:0] n, input logic [31:0] din);
    sr_ctrl = ctrl;
    sr_n    = n;
    data_in = din;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one command, hold mid_* on the inputs during SHIFT and DONE, then check latency and result
  task automatic runOp(input string tag, input logic [2:0] ctrl, input logic [4:0] n,
                       input logic [31:0] din, input logic [2:0] mid_ctrl, input logic [4:0] mid_n,
                       input logic [31:0] mid_din, input int exp_busy, input logic [31:0] exp_data);
    int cycles;
    cycles = 0;
    applyStimulus(ctrl, n, din);
    tick();
    applyStimulus(mid_ctrl, mid_n, mid_din);
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    checkOutput({tag, " busy cycles"}, 32'(cycles), 32'(exp_busy));
    checkOutput({tag, " done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, " data"}, data_out, exp_data);
    tick();
    applyStimulus(NOP, 5'd0, 32'd0);
    checkOutput({tag, " done pulse ends"}, {30'b0, busy, done}, 32'd0);
    checkOutput({tag, " data held"}, data_out, exp_data);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(NOP, 5'd0, 32'd0);
    tick();
    tick();
    checkOutput("reset data", data_out, 32'h0);
    checkOutput("reset busy/done", {30'b0, busy, done}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle nop", {30'b0, busy, done}, 32'd0);

    runOp("load F", LOAD, 5'd0, 32'h0000000F, LOAD, 5'd0, 32'hDEADBEEF, 0, 32'h0000000F);
    runOp("sll 4", SLL, 5'd4, 32'h0, NOP, 5'd0, 32'h0, 4, 32'h000000F0);

    runOp("load 80000000 a", LOAD, 5'd0, 32'h80000000, NOP, 5'd0, 32'h0, 0, 32'h80000000);
    runOp("sra 31", SRA, 5'd31, 32'h0, NOP, 5'd0, 32'h0, 31, 32'hFFFFFFFF);
    runOp("load 80000000 b", LOAD, 5'd0, 32'h80000000, NOP, 5'd0, 32'h0, 0, 32'h80000000);
    runOp("srl 31", SRL, 5'd31, 32'h0, NOP, 5'd0, 32'h0, 31, 32'h00000001);
    runOp("load 1 a", LOAD, 5'd0, 32'h00000001, NOP, 5'd0, 32'h0, 0, 32'h00000001);
    runOp("sll 31", SLL, 5'd31, 32'h0, NOP, 5'd0, 32'h0, 31, 32'h80000000);

    runOp("load 12345678", LOAD, 5'd0, 32'h12345678, NOP, 5'd0, 32'h0, 0, 32'h12345678);
    runOp("sll 0", SLL, 5'd0, 32'h0, NOP, 5'd0, 32'h0, 0, 32'h12345678);

    // Reset after three busy cycles of an 8-bit shift must abort with no done pulse
    runOp("load 1 b", LOAD, 5'd0, 32'h00000001, NOP, 5'd0, 32'h0, 0, 32'h00000001);
    applyStimulus(SLL, 5'd8, 32'h0);
    tick();
    applyStimulus(NOP, 5'd0, 32'h0);
    checkOutput("abort busy 1", {31'b0, busy}, 32'd1);
    tick();
    tick();
    checkOutput("abort busy 3", {31'b0, busy}, 32'd1);
    checkOutput("abort partial data", data_out, 32'h00000004);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort data", data_out, 32'h0);
    checkOutput("abort busy/done", {30'b0, busy, done}, 32'd0);
    tick();
    checkOutput("abort no done", {30'b0, busy, done}, 32'd0);
    runOp("load A5", LOAD, 5'd0, 32'h000000A5, NOP, 5'd0, 32'h0, 0, 32'h000000A5);

    runOp("load F0000000", LOAD, 5'd0, 32'hF0000000, NOP, 5'd0, 32'h0, 0, 32'hF0000000);
    runOp("srl 4 mid change", SRL, 5'd4, 32'h0, SLL, 5'd1, 32'h0, 4, 32'h0F000000);

    runOp("load 1 c", LOAD, 5'd0, 32'h00000001, NOP, 5'd0, 32'h0, 0, 32'h00000001);
`ifdef SHIFT_UNIT_ROTATE_EN
    runOp("ror 1", ROR, 5'd1, 32'h0, NOP, 5'd0, 32'h0, 1, 32'h80000000);
    runOp("rol 4", ROL, 5'd4, 32'h0, NOP, 5'd0, 32'h0, 4, 32'h00000008);
`else
    applyStimulus(ROR, 5'd1, 32'h0);
    tick();
    applyStimulus(NOP, 5'd0, 32'h0);
    checkOutput("ror disabled busy/done", {30'b0, busy, done}, 32'd0);
    checkOutput("ror disabled data", data_out, 32'h00000001);
    tick();
    checkOutput("ror disabled later", {30'b0, busy, done}, 32'd0);
    applyStimulus(ROL, 5'd4, 32'h0);
    tick();
    applyStimulus(NOP, 5'd0, 32'h0);
    checkOutput("rol disabled busy/done", {30'b0, busy, done}, 32'd0);
    checkOutput("rol disabled data", data_out, 32'h00000001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
